tmu_seq_ctrl: RTL and testbench

Sequencer that runs one control iteration of the TMU datapath per sample tick: it hands the latched feedback sample to the CORDIC unit, forms a saturated error from the CORDIC result and the setpoint, hands that error to the PID unit, and publishes the PID result as the new control output. It sits between the APB register block, which supplies the setpoint, timeout limit and error clear, and the CORDIC/PID engines, which it drives through req/ack handshakes. It also reports busy, overrun and timeout status back to the register block.

---
 rtl/tmu_pkg.sv | 18 +
 rtl/tmu_sat_sub.sv | 27 ++
 rtl/tmu_seq_ctrl.sv | 142 ++++++++++++++
 tb/tb_tmu_seq_ctrl.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmu_pkg.sv
// Shared types and constants for the TMU control sequencer.
package tmu_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CORDIC = 2'd1,
      PID    = 2'd2,
      DONE   = 2'd3
   } tmu_state_e;

   localparam int TMU_DW = 12;
   localparam int TMU_TW = 8;

   // Saturation limits at the default datapath width
   localparam logic signed [TMU_DW-1:0] TMU_SMAX = {1'b0, {(TMU_DW-1){1'b1}}};
   localparam logic signed [TMU_DW-1:0] TMU_SMIN = {1'b1, {(TMU_DW-1){1'b0}}};

endpackage

// File: rtl/tmu_sat_sub.sv
// Combinational signed saturating subtractor: y = sat(a - b) at DW bits.
module tmu_sat_sub
   import tmu_pkg::*;
#(
   parameter int DW = TMU_DW
) (
   input  logic signed [DW-1:0] a,
   input  logic signed [DW-1:0] b,
   output logic signed [DW-1:0] y
);

   localparam logic signed [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
   localparam logic signed [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};

   logic signed [DW:0] diff;

   always_comb begin
      diff = {a[DW-1], a} - {b[DW-1], b};
      // Overflow shows up as the two top bits of the widened result disagreeing
      if (diff[DW] != diff[DW-1]) begin
         y = diff[DW] ? SMIN : SMAX;
      end else begin
         y = diff[DW-1:0];
      end
   end

endmodule

// File: rtl/tmu_seq_ctrl.sv
// Per-tick control iteration sequencer: feedback -> CORDIC -> saturated error -> PID -> ctrl_out.
module tmu_seq_ctrl
   import tmu_pkg::*;
#(
   parameter int DW = TMU_DW,
   parameter int TW = TMU_TW
) (
   input  logic                 PCLK,
   input  logic                 PRESETn,
   input  logic                 enable,
   input  logic                 sample_tick,
   input  logic signed [DW-1:0] setpoint,
   input  logic signed [DW-1:0] feedback,
   input  logic [TW-1:0]        timeout_lim,
   input  logic                 err_clr,
   output logic                 cordic_req,
   output logic signed [DW-1:0] cordic_data,
   input  logic                 cordic_ack,
   input  logic signed [DW-1:0] cordic_result,
   output logic                 pid_req,
   output logic signed [DW-1:0] pid_data,
   input  logic                 pid_ack,
   input  logic signed [DW-1:0] pid_result,
   output logic signed [DW-1:0] ctrl_out,
   output logic                 ctrl_valid,
   output logic                 busy,
   output logic                 overrun_err,
   output logic                 timeout_err
);

   tmu_state_e          state_q, state_d;
   logic signed [DW-1:0] sp_q, sp_d;
   logic signed [DW-1:0] cordic_data_q, cordic_data_d;
   logic signed [DW-1:0] pid_data_q, pid_data_d;
   logic signed [DW-1:0] ctrl_out_q, ctrl_out_d;
   logic [TW-1:0]        wait_q, wait_d;
   logic                 overrun_q, overrun_d;
   logic                 timeout_q, timeout_d;
   logic signed [DW-1:0] err;
   logic                 waiting;
   logic                 limit_hit;

   tmu_sat_sub #(.DW(DW)) u_err_sub (
      .a (sp_q),
      .b (cordic_result),
      .y (err)
   );

   always_comb begin
      waiting   = ((state_q == CORDIC) && !cordic_ack) || ((state_q == PID) && !pid_ack);
      // Abort on the wait cycle that would bring the count up to the limit
      limit_hit = waiting && (timeout_lim != '0) &&
                  (({1'b0, wait_q} + (TW+1)'(1)) == {1'b0, timeout_lim});

      state_d       = state_q;
      sp_d          = sp_q;
      cordic_data_d = cordic_data_q;
      pid_data_d    = pid_data_q;
      ctrl_out_d    = ctrl_out_q;
      wait_d        = wait_q;
      overrun_d     = overrun_q & ~err_clr;
      timeout_d     = timeout_q & ~err_clr;

      case (state_q)
         IDLE: begin
            if (sample_tick && enable) begin
               state_d       = CORDIC;
               sp_d          = setpoint;
               cordic_data_d = feedback;
               wait_d        = '0;
            end
         end
         CORDIC: begin
            if (cordic_ack) begin
               pid_data_d = err;
               wait_d     = '0;
               state_d    = PID;
            end else if (limit_hit) begin
               timeout_d = 1'b1;
               state_d   = IDLE;
            end else begin
               wait_d = wait_q + TW'(1);
            end
         end
         PID: begin
            if (pid_ack) begin
               ctrl_out_d = pid_result;
               state_d    = DONE;
            end else if (limit_hit) begin
               timeout_d = 1'b1;
               state_d   = IDLE;
            end else begin
               wait_d = wait_q + TW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A tick that arrives while an iteration is in flight is lost
      if (sample_tick && (state_q != IDLE)) begin
         overrun_d = 1'b1;
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q       <= IDLE;
         sp_q          <= '0;
         cordic_data_q <= '0;
         pid_data_q    <= '0;
         ctrl_out_q    <= '0;
         wait_q        <= '0;
         overrun_q     <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         sp_q          <= sp_d;
         cordic_data_q <= cordic_data_d;
         pid_data_q    <= pid_data_d;
         ctrl_out_q    <= ctrl_out_d;
         wait_q        <= wait_d;
         overrun_q     <= overrun_d;
         timeout_q     <= timeout_d;
      end
   end

   assign cordic_req  = (state_q == CORDIC);
   assign pid_req     = (state_q == PID);
   assign ctrl_valid  = (state_q == DONE);
   assign busy        = (state_q != IDLE);
   assign cordic_data = cordic_data_q;
   assign pid_data    = pid_data_q;
   assign ctrl_out    = ctrl_out_q;
   assign overrun_err = overrun_q;
   assign timeout_err = timeout_q;

endmodule

// File: tb/tb_tmu_seq_ctrl.sv
// Self-checking bench for tmu_seq_ctrl with a handshake responder and an expected-result queue.
module tb_tmu_seq_ctrl;
   import tmu_pkg::*;

   localparam int DW = 12;
   localparam int TW = 8;

   logic          PCLK = 1'b0;
   logic          PRESETn = 1'b0;
   logic          enable = 1'b0;
   logic          sample_tick = 1'b0;
   logic [DW-1:0] setpoint = '0;
   logic [DW-1:0] feedback = '0;
   logic [TW-1:0] timeout_lim = '0;
   logic          err_clr = 1'b0;
   logic          cordic_req;
   logic [DW-1:0] cordic_data;
   logic          cordic_ack = 1'b0;
   logic [DW-1:0] cordic_result = '0;
   logic          pid_req;
   logic [DW-1:0] pid_data;
   logic          pid_ack = 1'b0;
   logic [DW-1:0] pid_result = '0;
   logic [DW-1:0] ctrl_out;
   logic          ctrl_valid;
   logic          busy;
   logic          overrun_err;
   logic          timeout_err;

   tmu_seq_ctrl #(.DW(DW), .TW(TW)) dut (
      .PCLK          (PCLK),
      .PRESETn       (PRESETn),
      .enable        (enable),
      .sample_tick   (sample_tick),
      .setpoint      (setpoint),
      .feedback      (feedback),
      .timeout_lim   (timeout_lim),
      .err_clr       (err_clr),
      .cordic_req    (cordic_req),
      .cordic_data   (cordic_data),
      .cordic_ack    (cordic_ack),
      .cordic_result (cordic_result),
      .pid_req       (pid_req),
      .pid_data      (pid_data),
      .pid_ack       (pid_ack),
      .pid_result    (pid_result),
      .ctrl_out      (ctrl_out),
      .ctrl_valid    (ctrl_valid),
      .busy          (busy),
      .overrun_err   (overrun_err),
      .timeout_err   (timeout_err)
   );

   always #5 PCLK = ~PCLK;

   int checks = 0;
   int passed = 0;

   // Handshake responder: ack after c_wait/p_wait stalled cycles unless hung
   int c_wait = 0, p_wait = 0, c_cnt = 0, p_cnt = 0;
   bit c_hang = 1'b0, p_hang = 1'b0;

   always @(posedge PCLK) begin
      #1;
      if (cordic_req && !c_hang && c_cnt >= c_wait) begin
         cordic_ack = 1'b1;
         c_cnt = 0;
      end else begin
         cordic_ack = 1'b0;
         c_cnt = cordic_req ? c_cnt + 1 : 0;
      end
      if (pid_req && !p_hang && p_cnt >= p_wait) begin
         pid_ack = 1'b1;
         p_cnt = 0;
      end else begin
         pid_ack = 1'b0;
         p_cnt = pid_req ? p_cnt + 1 : 0;
      end
   end

   typedef struct {
      logic [DW-1:0] pd;
      logic [DW-1:0] co;
   } exp_t;

   exp_t exp_q[$];
   exp_t ex;
   logic [DW-1:0] last_co = '0;

   int obs_cr, obs_pr, obs_busy, obs_vn, obs_valid_at;
   logic [DW-1:0] obs_cd, obs_pd, obs_co;
   bit obs_done;
   int tick_at = 0, clr_at = 0, en_off_at = 0;

   function automatic logic [DW-1:0] exp_err(input logic [DW-1:0] sp, input logic [DW-1:0] r);
      int d;
      d = int'($signed(sp)) - int'($signed(r));
      if (d > 2047) d = 2047;
      if (d < -2048) d = -2048;
      return d[DW-1:0];
   endfunction

   function automatic exp_t pop_exp();
      exp_t e;
      e.pd = 'x;
      e.co = 'x;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      return e;
   endfunction

   // Drives one tick at the current cycle (T) and records what the DUT does over T+1..
   task automatic run_iter(input logic [DW-1:0] sp, input logic [DW-1:0] fb,
                           input logic [DW-1:0] cres, input logic [DW-1:0] pres,
                           input int cw, input int pw);
      setpoint = sp; feedback = fb; cordic_result = cres; pid_result = pres;
      c_wait = cw; p_wait = pw;
      obs_cr = 0; obs_pr = 0; obs_busy = 0; obs_vn = 0; obs_valid_at = 0;
      obs_cd = '0; obs_pd = '0; obs_co = '0; obs_done = 1'b0;
      enable = 1'b1;
      sample_tick = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge PCLK); #1;
         sample_tick = (k == tick_at);
         err_clr = (k == clr_at);
         if (k == en_off_at) enable = 1'b0;
         if (cordic_req) begin obs_cr++; obs_cd = cordic_data; end
         if (pid_req) begin obs_pr++; obs_pd = pid_data; end
         if (busy) obs_busy++;
         if (ctrl_valid) begin obs_vn++; obs_valid_at = k; obs_co = ctrl_out; end
         if (!busy) begin obs_done = 1'b1; break; end
      end
      sample_tick = 1'b0; err_clr = 1'b0; enable = 1'b1;
      tick_at = 0; clr_at = 0; en_off_at = 0;
   endtask

   task automatic test_reset();
      PRESETn = 1'b0;
      repeat (2) @(posedge PCLK);
      #1;
      checks++;
      if ({cordic_req, pid_req, ctrl_valid, busy} !== 4'b0)
         $display("FAIL reset_ctrl: got %b want 0000", {cordic_req, pid_req, ctrl_valid, busy});
      else passed++;
      checks++;
      if ({cordic_data, pid_data, ctrl_out} !== '0)
         $display("FAIL reset_data: got %h/%h/%h want 0", cordic_data, pid_data, ctrl_out);
      else passed++;
      checks++;
      if ({overrun_err, timeout_err} !== 2'b0)
         $display("FAIL reset_flags: got %b want 00", {overrun_err, timeout_err});
      else passed++;
      PRESETn = 1'b1;
      @(posedge PCLK); #1;
   endtask

   task automatic test_basic();
      exp_q.push_back('{exp_err(12'h100, 12'h040), 12'h123});
      run_iter(12'h100, 12'h050, 12'h040, 12'h123, 0, 0);
      ex = pop_exp();
      last_co = ex.co;
      checks++;
      if (obs_cd !== 12'h050) $display("FAIL basic_cordic_data: got %h want 050", obs_cd); else passed++;
      checks++;
      if (obs_pd !== ex.pd) $display("FAIL basic_pid_data: got %h want %h", obs_pd, ex.pd); else passed++;
      checks++;
      if (obs_co !== ex.co) $display("FAIL basic_ctrl_out: got %h want %h", obs_co, ex.co); else passed++;
      checks++;
      if (obs_valid_at !== 3 || obs_vn !== 1)
         $display("FAIL basic_valid: at T+%0d count %0d want T+3 count 1", obs_valid_at, obs_vn);
      else passed++;
      checks++;
      if (obs_busy !== 3 || !obs_done)
         $display("FAIL basic_busy: got %0d cycles want 3", obs_busy);
      else passed++;
      checks++;
      if (obs_cr !== 1 || obs_pr !== 1)
         $display("FAIL basic_req_cycles: got cr %0d pr %0d want 1 1", obs_cr, obs_pr);
      else passed++;
      checks++;
      if (ctrl_out !== 12'h123) $display("FAIL basic_hold: got %h want 123", ctrl_out); else passed++;
   endtask

   task automatic test_saturation();
      logic [DW-1:0] sp_v[2];
      logic [DW-1:0] cr_v[2];
      logic [DW-1:0] want[2];
      sp_v = '{12'h7FF, 12'h800};
      cr_v = '{12'h800, 12'h001};
      want = '{12'h7FF, 12'h800};
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back('{exp_err(sp_v[i], cr_v[i]), 12'h300 + 12'(i)});
         run_iter(sp_v[i], 12'h000, cr_v[i], 12'h300 + 12'(i), 0, 0);
         ex = pop_exp();
         last_co = ex.co;
         checks++;
         if (obs_pd !== ex.pd || obs_pd !== want[i])
            $display("FAIL sat_pid_data_%0d: got %h want %h", i, obs_pd, want[i]);
         else passed++;
         checks++;
         if (obs_co !== ex.co) $display("FAIL sat_ctrl_out_%0d: got %h want %h", i, obs_co, ex.co);
         else passed++;
      end
   endtask

   task automatic test_wait_latency();
      exp_q.push_back('{exp_err(12'h010, 12'h020), 12'h456});
      en_off_at = 1;
      run_iter(12'h010, 12'h0AA, 12'h020, 12'h456, 2, 1);
      ex = pop_exp();
      last_co = ex.co;
      checks++;
      if (obs_valid_at !== 6 || obs_vn !== 1)
         $display("FAIL wait_latency: valid at T+%0d count %0d want T+6 count 1", obs_valid_at, obs_vn);
      else passed++;
      checks++;
      if (obs_cr !== 3 || obs_pr !== 2)
         $display("FAIL wait_req_cycles: got cr %0d pr %0d want 3 2", obs_cr, obs_pr);
      else passed++;
      checks++;
      if (obs_pd !== ex.pd || obs_co !== ex.co)
         $display("FAIL wait_data: got %h/%h want %h/%h", obs_pd, obs_co, ex.pd, ex.co);
      else passed++;
   endtask

   task automatic test_enable_gate();
      enable = 1'b0;
      sample_tick = 1'b1;
      @(posedge PCLK); #1;
      sample_tick = 1'b0;
      checks++;
      if (busy !== 1'b0 || overrun_err !== 1'b0)
         $display("FAIL enable_gate: got busy %b overrun %b want 0 0", busy, overrun_err);
      else passed++;
      enable = 1'b1;
   endtask

   task automatic test_timeout();
      timeout_lim = 8'd3;
      c_hang = 1'b1;
      run_iter(12'h111, 12'h222, 12'h000, 12'h777, 0, 0);
      c_hang = 1'b0;
      checks++;
      if (obs_cr !== 3 || obs_pr !== 0)
         $display("FAIL timeout_req_cycles: got cr %0d pr %0d want 3 0", obs_cr, obs_pr);
      else passed++;
      checks++;
      if (obs_vn !== 0 || !obs_done)
         $display("FAIL timeout_abort: valid count %0d idle %0d want 0 1", obs_vn, obs_done);
      else passed++;
      checks++;
      if (timeout_err !== 1'b1) $display("FAIL timeout_flag: got %b want 1", timeout_err); else passed++;
      checks++;
      if (ctrl_out !== last_co) $display("FAIL timeout_ctrl_out: got %h want %h", ctrl_out, last_co);
      else passed++;
      err_clr = 1'b1;
      @(posedge PCLK); #1;
      err_clr = 1'b0;
      checks++;
      if (timeout_err !== 1'b0) $display("FAIL timeout_clear: got %b want 0", timeout_err); else passed++;
   endtask

   task automatic test_limit_ack();
      timeout_lim = 8'd2;
      exp_q.push_back('{exp_err(12'h050, 12'h060), 12'h0AB});
      run_iter(12'h050, 12'h001, 12'h060, 12'h0AB, 1, 1);
      ex = pop_exp();
      last_co = ex.co;
      timeout_lim = 8'd0;
      checks++;
      if (obs_vn !== 1 || obs_valid_at !== 5)
         $display("FAIL limit_ack_valid: at T+%0d count %0d want T+5 count 1", obs_valid_at, obs_vn);
      else passed++;
      checks++;
      if (timeout_err !== 1'b0) $display("FAIL limit_ack_flag: got %b want 0", timeout_err); else passed++;
      checks++;
      if (obs_pd !== ex.pd || obs_co !== ex.co)
         $display("FAIL limit_ack_data: got %h/%h want %h/%h", obs_pd, obs_co, ex.pd, ex.co);
      else passed++;
   endtask

   task automatic test_overrun();
      tick_at = 2;
      exp_q.push_back('{exp_err(12'h200, 12'h100), 12'h321});
      run_iter(12'h200, 12'h003, 12'h100, 12'h321, 0, 0);
      ex = pop_exp();
      last_co = ex.co;
      checks++;
      if (overrun_err !== 1'b1) $display("FAIL overrun_set: got %b want 1", overrun_err); else passed++;
      checks++;
      if (obs_vn !== 1 || obs_valid_at !== 3 || obs_co !== ex.co)
         $display("FAIL overrun_complete: T+%0d count %0d out %h want T+3 1 %h",
                  obs_valid_at, obs_vn, obs_co, ex.co);
      else passed++;
      err_clr = 1'b1;
      @(posedge PCLK); #1;
      err_clr = 1'b0;
      checks++;
      if (overrun_err !== 1'b0) $display("FAIL overrun_clear: got %b want 0", overrun_err); else passed++;
      tick_at = 3;
      clr_at = 3;
      exp_q.push_back('{exp_err(12'h005, 12'h003), 12'h0F0});
      run_iter(12'h005, 12'h004, 12'h003, 12'h0F0, 0, 0);
      ex = pop_exp();
      last_co = ex.co;
      checks++;
      if (overrun_err !== 1'b1) $display("FAIL overrun_set_wins: got %b want 1", overrun_err); else passed++;
      @(posedge PCLK); #1;
      checks++;
      if (busy !== 1'b0 || obs_vn !== 1)
         $display("FAIL overrun_dropped: busy %b valid count %0d want 0 1", busy, obs_vn);
      else passed++;
      err_clr = 1'b1;
      @(posedge PCLK); #1;
      err_clr = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] got_co[2];
      int got_at[2];
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back('{exp_err(12'h040, 12'(i)), 12'h500 + 12'(i)});
         run_iter(12'h040, 12'h000, 12'(i), 12'h500 + 12'(i), 0, 0);
         got_co[i] = obs_co;
         got_at[i] = obs_valid_at;
      end
      for (int i = 0; i < 2; i++) begin
         ex = pop_exp();
         checks++;
         if (got_co[i] !== ex.co || got_at[i] !== 3)
            $display("FAIL b2b_iter_%0d: out %h at T+%0d want %h at T+3", i, got_co[i], got_at[i], ex.co);
         else passed++;
      end
      last_co = 12'h501;
      checks++;
      if (overrun_err !== 1'b0) $display("FAIL b2b_no_overrun: got %b want 0", overrun_err); else passed++;
   endtask

   task automatic test_reset_mid();
      bit seen;
      seen = 1'b0;
      p_hang = 1'b1;
      setpoint = 12'h0AA; feedback = 12'h011; cordic_result = 12'h00A; pid_result = 12'h3C3;
      c_wait = 0; p_wait = 0;
      sample_tick = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(posedge PCLK); #1;
         sample_tick = 1'b0;
         if (pid_req) begin seen = 1'b1; break; end
      end
      checks++;
      if (!seen) $display("FAIL rst_mid_reach_pid: got no pid_req want pid_req"); else passed++;
      #2;
      PRESETn = 1'b0;
      #1;
      checks++;
      if ({cordic_req, pid_req, ctrl_valid, busy} !== 4'b0)
         $display("FAIL rst_mid_ctrl: got %b want 0000", {cordic_req, pid_req, ctrl_valid, busy});
      else passed++;
      checks++;
      if ({cordic_data, pid_data, ctrl_out, overrun_err, timeout_err} !== '0)
         $display("FAIL rst_mid_data: got %h/%h/%h want 0", cordic_data, pid_data, ctrl_out);
      else passed++;
      p_hang = 1'b0;
      @(posedge PCLK); #1;
      PRESETn = 1'b1;
      @(posedge PCLK); #1;
      exp_q.push_back('{exp_err(12'h0AA, 12'h00A), 12'h3C3});
      run_iter(12'h0AA, 12'h011, 12'h00A, 12'h3C3, 0, 0);
      ex = pop_exp();
      checks++;
      if (obs_vn !== 1 || obs_valid_at !== 3 || obs_co !== ex.co || obs_pd !== ex.pd)
         $display("FAIL rst_mid_after: out %h pd %h at T+%0d want %h %h at T+3",
                  obs_co, obs_pd, obs_valid_at, ex.co, ex.pd);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_saturation();
      test_wait_latency();
      test_enable_gate();
      test_timeout();
      test_limit_ack();
      test_overrun();
      test_back_to_back();
      test_reset_mid();
      checks++;
      if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
      else passed++;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish before 200000");
      $fatal(1, "watchdog expired");
   end

endmodule
